regfile_dump_reader: RTL and testbench

- Sequential read-side client of the core's 32x32 register file. Walks an address range on one asynchronous read port and streams each register out as an (address, data) beat on a valid/ready interface.
- Used by debug/trace logic and test benches to snapshot architectural state without stalling the core's write port.
- Sits beside the register file and drives a dedicated read-address input. It never writes.

---
 rtl/regfile_dump_reader.sv | 152 +++++++++++++++
 tb/tb_regfile_dump_reader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks an address range on an async read port and
// streams (address, data) beats over valid/ready, one beat per two cycles.
module regfile_dump_reader #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter bit SKIP_X0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_sent
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     words_q, words_d;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return p + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [ADDR_W:0] words_inc(input logic [ADDR_W:0] w);
        return w + {{ADDR_W{1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        words_d     = words_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = first_addr;
                    last_d  = last_addr;
                    words_d = '0;
                    // A range of just x0 has nothing to emit when x0 is skipped.
                    if (SKIP_X0 && (first_addr == '0) && (last_addr == '0)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end else if (SKIP_X0 && (ptr_q == '0)) begin
                    if (ptr_q == last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_inc(ptr_q);
                    end
                end else begin
                    out_addr_d  = ptr_q;
                    out_data_d  = rf_data;
                    out_valid_d = 1'b1;
                    state_d     = S_SEND;
                end
            end

            S_SEND: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end else if (out_ready) begin
                    words_d     = words_inc(words_q);
                    out_valid_d = 1'b0;
                    if (ptr_q == last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d   = ptr_inc(ptr_q);
                        state_d = S_READ;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            last_q      <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            words_q     <= words_d;
        end
    end

    assign rf_addr    = ptr_q;
    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;
    assign done       = done_q;
    assign busy       = (state_q == S_READ) || (state_q == S_SEND);
    assign words_sent = words_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: one instance with x0 emitted, one with x0
// skipped, a shared register-file model, and a beat scoreboard per instance.
module tb_regfile_dump_reader;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start0, start1, abort, out_ready;
    logic [AW-1:0] first_addr, last_addr;
    logic [AW-1:0] rf_addr0, rf_addr1, out_addr0, out_addr1;
    logic [DW-1:0] rf_data0, rf_data1, out_data0, out_data1;
    logic          out_valid0, out_valid1, busy0, busy1, done0, done1;
    logic [AW:0]   ws0, ws1;

    logic [DW-1:0] rf [32];
    logic          preload, we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 + 32'(i);
        end else if (we) begin
            rf[wa] <= wd;
        end
    end

    assign rf_data0 = rf[rf_addr0];
    assign rf_data1 = rf[rf_addr1];

    regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .SKIP_X0(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .rf_addr(rf_addr0), .rf_data(rf_data0),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_addr(out_addr0), .out_data(out_data0),
        .busy(busy0), .done(done0), .words_sent(ws0)
    );

    regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .SKIP_X0(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .rf_addr(rf_addr1), .rf_data(rf_data1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_addr(out_addr1), .out_data(out_data1),
        .busy(busy1), .done(done1), .words_sent(ws1)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int checks = 0;
    int errors = 0;
    int dcnt0 = 0;
    int dcnt1 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Beats are sampled mid-cycle; valid&&ready here means transfer at next edge.
    always @(negedge clk) begin
        beat_t b;
        if (done0) dcnt0++;
        if (done1) dcnt1++;
        if (out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat0_unexpected: got addr %0h data %0h expected none", out_addr0, out_data0);
            end else begin
                b = q0.pop_front();
                chk("beat0_addr", 64'(out_addr0), 64'(b.a));
                chk("beat0_data", 64'(out_data0), 64'(b.d));
            end
        end
        if (out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat1_unexpected: got addr %0h data %0h expected none", out_addr1, out_data1);
            end else begin
                b = q1.pop_front();
                chk("beat1_addr", 64'(out_addr1), 64'(b.a));
                chk("beat1_data", 64'(out_data1), 64'(b.d));
            end
        end
    end

    task automatic push_beat(input int sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
        beat_t b;
        b.a = a;
        b.d = d;
        if (sel == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    task automatic push_range(input int sel, input logic [AW-1:0] f, input logic [AW-1:0] l);
        logic [AW-1:0] a;
        a = f;
        for (int k = 0; k < 32; k++) begin
            if (!(sel == 1 && a == '0)) push_beat(sel, a, 32'h1000_0000 + 32'(a));
            if (a == l) break;
            a = a + 5'd1;
        end
    endtask

    // Returns #1 after the edge that samples start.
    task automatic start_dump(input int sel, input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(posedge clk); #1;
        first_addr = f;
        last_addr  = l;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if ((sel == 0) ? done0 : done1) begin
                cyc = i;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_valid0(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_valid0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        int            sel;
        logic [AW-1:0] f;
        logic [AW-1:0] l;
        int            exp_n;
        bit            lat;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   cyc, d_before, wsv;
        bit   ok;

        tbl[0] = '{0, 5'd0,  5'd31, 32, 1'b1};
        tbl[1] = '{0, 5'd30, 5'd1,  4,  1'b0};
        tbl[2] = '{1, 5'd30, 5'd1,  3,  1'b0};
        tbl[3] = '{0, 5'd9,  5'd9,  1,  1'b0};
        tbl[4] = '{1, 5'd0,  5'd31, 31, 1'b0};
        tbl[5] = '{1, 5'd31, 5'd31, 1,  1'b0};

        rst = 1'b1; start0 = 0; start1 = 0; abort = 0; out_ready = 1'b1;
        first_addr = '0; last_addr = '0; preload = 1'b1; we = 0; wa = '0; wd = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; preload = 1'b0;

        chk("rst_valid", 64'(out_valid0), 64'd0);
        chk("rst_addr",  64'(out_addr0),  64'd0);
        chk("rst_data",  64'(out_data0),  64'd0);
        chk("rst_rfaddr", 64'(rf_addr0),  64'd0);
        chk("rst_busy",  64'(busy0),      64'd0);
        chk("rst_done",  64'(done0),      64'd0);
        chk("rst_words", 64'(ws0),        64'd0);

        for (int t = 0; t < 6; t++) begin
            out_ready = 1'b1;
            push_range(tbl[t].sel, tbl[t].f, tbl[t].l);
            d_before = (tbl[t].sel == 0) ? dcnt0 : dcnt1;
            start_dump(tbl[t].sel, tbl[t].f, tbl[t].l);
            if (tbl[t].lat) begin
                chk("lat_read_valid", 64'(out_valid0), 64'd0);
                chk("lat_read_busy",  64'(busy0),      64'd1);
                @(posedge clk); #1;
                chk("lat_send_valid", 64'(out_valid0), 64'd1);
                chk("lat_send_addr",  64'(out_addr0),  64'd0);
            end
            wait_done(tbl[t].sel, 200, cyc);
            chk("case_done_seen", 64'(cyc >= 0), 64'd1);
            @(posedge clk); #1;
            wsv = (tbl[t].sel == 0) ? int'(ws0) : int'(ws1);
            chk("case_words", 64'(wsv), 64'(tbl[t].exp_n));
            chk("case_queue_empty", 64'((tbl[t].sel == 0) ? q0.size() : q1.size()), 64'd0);
            chk("case_done_pulses", 64'(((tbl[t].sel == 0) ? dcnt0 : dcnt1) - d_before), 64'd1);
            chk("case_busy_idle", 64'((tbl[t].sel == 0) ? busy0 : busy1), 64'd0);
        end

        // Backpressure on the x7 beat.
        out_ready = 1'b0;
        push_range(0, 5'd7, 5'd8);
        start_dump(0, 5'd7, 5'd8);
        wait_valid0(10, ok);
        chk("bp_valid_seen", 64'(ok), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", 64'(out_valid0), 64'd1);
            chk("bp_hold_addr",  64'(out_addr0),  64'd7);
            chk("bp_hold_data",  64'(out_data0),  64'h1000_0007);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(0, 50, cyc);
        chk("bp_done_seen", 64'(cyc >= 0), 64'd1);
        chk("bp_words", 64'(ws0), 64'd2);
        chk("bp_queue_empty", 64'(q0.size()), 64'd0);

        // Core write on the capture edge is not seen; the next dump sees it.
        push_beat(0, 5'd5, 32'h1000_0005);
        start_dump(0, 5'd5, 5'd5);
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        we = 1'b0;
        wait_done(0, 20, cyc);
        chk("race_done_seen", 64'(cyc >= 0), 64'd1);
        chk("race_queue_empty", 64'(q0.size()), 64'd0);
        push_beat(0, 5'd5, 32'hDEAD_BEEF);
        start_dump(0, 5'd5, 5'd5);
        wait_done(0, 20, cyc);
        chk("race2_done_seen", 64'(cyc >= 0), 64'd1);
        chk("race2_queue_empty", 64'(q0.size()), 64'd0);
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;

        // Abort after three accepted beats.
        out_ready = 1'b1;
        push_beat(0, 5'd10, 32'h1000_000A);
        push_beat(0, 5'd11, 32'h1000_000B);
        push_beat(0, 5'd12, 32'h1000_000C);
        d_before = dcnt0;
        start_dump(0, 5'd10, 5'd20);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ws0 == 6'd3) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("abort_three_sent", 64'(ok), 64'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", 64'(out_valid0), 64'd0);
        chk("abort_busy",  64'(busy0),      64'd0);
        chk("abort_words", 64'(ws0),        64'd3);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(dcnt0 - d_before), 64'd0);
        chk("abort_words_hold", 64'(ws0), 64'd3);
        chk("abort_queue_empty", 64'(q0.size()), 64'd0);
        push_range(0, 5'd2, 5'd3);
        start_dump(0, 5'd2, 5'd3);
        chk("restart_words_clear", 64'(ws0), 64'd0);
        wait_done(0, 20, cyc);
        chk("restart_done_seen", 64'(cyc >= 0), 64'd1);
        chk("restart_words", 64'(ws0), 64'd2);

        // Reset while a beat is pending.
        out_ready = 1'b0;
        start_dump(0, 5'd4, 5'd6);
        wait_valid0(10, ok);
        chk("rsend_valid_seen", 64'(ok), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rsend_valid",  64'(out_valid0), 64'd0);
        chk("rsend_addr",   64'(out_addr0),  64'd0);
        chk("rsend_data",   64'(out_data0),  64'd0);
        chk("rsend_rfaddr", 64'(rf_addr0),   64'd0);
        chk("rsend_busy",   64'(busy0),      64'd0);
        chk("rsend_words",  64'(ws0),        64'd0);
        out_ready = 1'b1;

        // Skipped x0 as the whole range: done one cycle after start, no beats.
        d_before = dcnt1;
        start_dump(1, 5'd0, 5'd0);
        chk("skip0_done",  64'(done1),      64'd1);
        chk("skip0_valid", 64'(out_valid1), 64'd0);
        chk("skip0_busy",  64'(busy1),      64'd0);
        @(posedge clk); #1;
        chk("skip0_done_low", 64'(done1), 64'd0);
        chk("skip0_words", 64'(ws1), 64'd0);
        chk("skip0_pulses", 64'(dcnt1 - d_before), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("final_q0_empty", 64'(q0.size()), 64'd0);
        chk("final_q1_empty", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
